// File: rtl/test_phase_pkg.sv
// Shared types and default timeouts for the test-phase sequencer.
package test_phase_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_BOOT = 3'd1,
    PH_CKPT = 3'd2,
    PH_RUN  = 3'd3,
    PH_PASS = 3'd4,
    PH_FAIL = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    FAIL_NONE = 2'd0,
    FAIL_BOOT = 2'd1,
    FAIL_RUN  = 2'd2
  } fail_e;

  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_BOOT_TO = 16;
  localparam int unsigned DEF_RUN_TO  = 50;

endpackage

// File: rtl/test_phase_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/test_phase_ctrl.sv
// Sequences a simulation run through boot, checkpoint and run with a
// per-phase cycle watchdog; the verdict is sticky until reset.
module test_phase_ctrl
  import test_phase_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned BOOT_TO = DEF_BOOT_TO,
  parameter int unsigned RUN_TO  = DEF_RUN_TO,
  parameter bit          CKPT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             boot_req,
  input  logic             boot_done,
  output logic             ckpt_req,
  input  logic             ckpt_ack,
  output logic             run_en,
  input  logic             end_test,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_TO - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TO - 1);

  phase_e state_q, state_d;
  fail_e  fail_q,  fail_d;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      PH_IDLE: if (start) state_d = PH_BOOT;
      // Completion is tested before the watchdog so it wins a same-cycle race.
      PH_BOOT: begin
        if (boot_done) begin
          state_d = CKPT_EN ? PH_CKPT : PH_RUN;
        end else if (cycle_cnt == BOOT_LAST) begin
          state_d = PH_FAIL;
          fail_d  = FAIL_BOOT;
        end
      end
      PH_CKPT: if (ckpt_ack) state_d = PH_RUN;
      PH_RUN: begin
        if (end_test) begin
          state_d = PH_PASS;
        end else if (cycle_cnt == RUN_LAST) begin
          state_d = PH_FAIL;
          fail_d  = FAIL_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_IDLE;
      fail_q  <= FAIL_NONE;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_d != state_q),
    .cnt (cycle_cnt)
  );

  // Outputs decode only registered state, so no input reaches them combinationally.
  assign boot_req  = (state_q == PH_BOOT);
  assign ckpt_req  = (state_q == PH_CKPT);
  assign run_en    = (state_q == PH_RUN);
  assign pass      = (state_q == PH_PASS);
  assign done      = (state_q == PH_PASS) || (state_q == PH_FAIL);
  assign fail_code = fail_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_test_phase_ctrl.sv
// Bench for test_phase_ctrl: scenario timelines built from the phase rules,
// with randomized noise on inputs that the current phase does not own.
module tb_test_phase_ctrl;

  localparam int BOOT_TO = 16;
  localparam int RUN_TO  = 50;

  logic clk = 1'b0;
  logic rst, start, boot_done, ckpt_ack, end_test;

  logic        br_a, cr_a, re_a, dn_a, ps_a;
  logic [1:0]  fc_a;
  logic [2:0]  ph_a;
  logic [15:0] cc_a;
  logic        br_b, cr_b, re_b, dn_b, ps_b;
  logic [1:0]  fc_b;
  logic [2:0]  ph_b;
  logic [15:0] cc_b;
  logic        br_s, cr_s, re_s, dn_s, ps_s;
  logic [1:0]  fc_s;
  logic [2:0]  ph_s;
  logic [3:0]  cc_s;

  bit use_nc = 1'b0;
  logic [2:0]  ph_m;
  logic [15:0] cc_m;
  logic [6:0]  fl_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  test_phase_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start), .boot_req(br_a), .boot_done(boot_done),
    .ckpt_req(cr_a), .ckpt_ack(ckpt_ack), .run_en(re_a), .end_test(end_test),
    .done(dn_a), .pass(ps_a), .fail_code(fc_a), .phase(ph_a), .cycle_cnt(cc_a)
  );

  test_phase_ctrl #(.CKPT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .boot_req(br_b), .boot_done(boot_done),
    .ckpt_req(cr_b), .ckpt_ack(ckpt_ack), .run_en(re_b), .end_test(end_test),
    .done(dn_b), .pass(ps_b), .fail_code(fc_b), .phase(ph_b), .cycle_cnt(cc_b)
  );

  test_phase_ctrl #(.CNT_W(4), .BOOT_TO(8), .RUN_TO(10)) dut_s (
    .clk(clk), .rst(rst), .start(start), .boot_req(br_s), .boot_done(boot_done),
    .ckpt_req(cr_s), .ckpt_ack(ckpt_ack), .run_en(re_s), .end_test(end_test),
    .done(dn_s), .pass(ps_s), .fail_code(fc_s), .phase(ph_s), .cycle_cnt(cc_s)
  );

  assign ph_m = use_nc ? ph_b : ph_a;
  assign cc_m = use_nc ? cc_b : cc_a;
  assign fl_m = use_nc ? {br_b, cr_b, re_b, dn_b, ps_b, fc_b}
                       : {br_a, cr_a, re_a, dn_a, ps_a, fc_a};

  typedef struct {
    int ph;
    int cnt;
    int fc;
    bit fire;
  } step_t;

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; boot_done = 1'b0; ckpt_ack = 1'b0; end_test = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected flags from the phase meaning: boot_req, ckpt_req, run_en, done, pass, fail_code.
  function automatic logic [6:0] flags_of(int ph, int fc);
    return {ph == 1, ph == 2, ph == 3, ph >= 4, ph == 4, 2'(fc)};
  endfunction

  // b/c/r: cycle index inside BOOT/CKPT/RUN at which the owned input fires;
  // an index at or past the timeout means it never fires.
  task automatic run_scenario(input string name, input bit nc, input int b,
                              input int c, input int r);
    step_t q[$];
    int term, fc, run_exp, run_obs;
    use_nc = nc;
    q.push_back('{0, 0, 0, 1'b1});
    term = 4; fc = 0; run_exp = 0; run_obs = 0;
    if (b < BOOT_TO) begin
      for (int i = 0; i <= b; i++) q.push_back('{1, i, 0, i == b});
      if (!nc) for (int i = 0; i <= c; i++) q.push_back('{2, i, 0, i == c});
      if (r < RUN_TO) begin
        for (int i = 0; i <= r; i++) q.push_back('{3, i, 0, i == r});
        run_exp = r + 1;
      end else begin
        for (int i = 0; i < RUN_TO; i++) q.push_back('{3, i, 0, 1'b0});
        run_exp = RUN_TO; term = 5; fc = 2;
      end
    end else begin
      for (int i = 0; i < BOOT_TO; i++) q.push_back('{1, i, 0, 1'b0});
      term = 5; fc = 1;
    end
    for (int i = 0; i < 6; i++) q.push_back('{term, i, fc, 1'b0});

    do_reset();
    foreach (q[k]) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (ph_m !== 3'(q[k].ph)) begin
        n_bad++;
        $display("FAIL %s phase step %0d: got %0d want %0d", name, k, ph_m, q[k].ph);
      end
      n_cmp++;
      if (cc_m !== 16'(q[k].cnt)) begin
        n_bad++;
        $display("FAIL %s cycle_cnt step %0d: got %0d want %0d", name, k, cc_m, q[k].cnt);
      end
      n_cmp++;
      if (fl_m !== flags_of(q[k].ph, q[k].fc)) begin
        n_bad++;
        $display("FAIL %s flags step %0d: got %b want %b", name, k, fl_m,
                 flags_of(q[k].ph, q[k].fc));
      end
      if (fl_m[4] === 1'b1) run_obs++;
      start     = (q[k].ph == 0) ? q[k].fire : 1'($urandom_range(1, 0));
      boot_done = (q[k].ph == 1) ? q[k].fire : 1'($urandom_range(1, 0));
      ckpt_ack  = (q[k].ph == 2) ? q[k].fire : 1'($urandom_range(1, 0));
      end_test  = (q[k].ph == 3) ? q[k].fire : 1'($urandom_range(1, 0));
    end
    n_cmp++;
    if (run_obs != run_exp) begin
      n_bad++;
      $display("FAIL %s run_en cycles: got %0d want %0d", name, run_obs, run_exp);
    end
    start = 1'b0; boot_done = 1'b0; ckpt_ack = 1'b0; end_test = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ph_a, cc_a, br_a, cr_a, re_a, dn_a, ps_a, fc_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got ph=%0d cnt=%0d flags=%b want all 0",
               ph_a, cc_a, {br_a, cr_a, re_a, dn_a, ps_a, fc_a});
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start = 1'b1;
    @(negedge clk); start = 1'b0; boot_done = 1'b1;
    @(negedge clk); boot_done = 1'b0; ckpt_ack = 1'b1;
    @(negedge clk); ckpt_ack = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (ph_a !== 3'd3 || cc_a !== 16'd20 || re_a !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_run_before_rst: got ph=%0d cnt=%0d run_en=%b want 3/20/1",
               ph_a, cc_a, re_a);
    end
    rst = 1'b1; ckpt_ack = 1'b1; boot_done = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ph_a, cc_a, br_a, cr_a, re_a, dn_a, ps_a, fc_a} !== '0) begin
      n_bad++;
      $display("FAIL mid_run_rst: got ph=%0d cnt=%0d flags=%b want all 0",
               ph_a, cc_a, {br_a, cr_a, re_a, dn_a, ps_a, fc_a});
    end
    rst = 1'b0; ckpt_ack = 1'b0; boot_done = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i >= 13) begin
        n_cmp++;
        if (cc_s !== 4'((i < 15) ? i : 15)) begin
          n_bad++;
          $display("FAIL saturate idle cycle %0d: got %0d want %0d", i, cc_s,
                   (i < 15) ? i : 15);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    run_scenario("happy", 1'b0, 3, 2, 9);
    run_scenario("min_latency", 1'b0, 0, 0, 0);
    run_scenario("boot_timeout", 1'b0, 99, 0, 0);
    run_scenario("boot_race", 1'b0, BOOT_TO - 1, 1, 4);
    run_scenario("run_timeout", 1'b0, 1, 1, 99);
    run_scenario("run_race", 1'b0, 0, 0, RUN_TO - 1);
    run_scenario("no_ckpt", 1'b1, 2, 0, 5);
    run_scenario("no_ckpt_timeout", 1'b1, 4, 0, 99);
    for (int i = 0; i < 12; i++) begin
      run_scenario("random", 1'($urandom_range(1, 0)), int'($urandom_range(18, 0)),
                   int'($urandom_range(4, 0)), int'($urandom_range(52, 0)));
    end
    test_reset_mid_run();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
